axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3 slave responder backed by an on-chip word-addressed SRAM array. It is the far end of the cache AXI master interface: it accepts AR/AW bursts, returns R beats and B responses.
- Used as the simulation/test memory and as on-chip scratch RAM behind the crossbar.
- One read burst and one write burst may be in flight at once, on independent channels.

Parameters:
- ADDR_BITS, 12, word-index width; the array holds 2^ADDR_BITS 32-bit words.
- INIT_ZERO, 1, when 1 the array is zero-filled at time 0 (simulation only); reset never clears it.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- arid  in  4  read ID
- araddr  in  32  read start byte address
- arlen  in  8  beats minus 1
- arsize  in  3  bytes per beat = 1<<arsize, max 3'b010
- arburst  in  2  00 FIXED, 01 INCR, others treated as INCR
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  4  echoes the latched arid
- rdata  out  32  read data, full aligned word
- rresp  out  2  00 OKAY, 11 DECERR
- rlast  out  1  final beat
- rvalid  out  1  R valid
- rready  in  1  R ready
- awid  in  4  write ID
- awaddr  in  32  write start byte address
- awlen  in  8  beats minus 1
- awsize  in  3  as arsize
- awburst  in  2  as arburst
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wid  in  4  ignored
- wdata  in  32  write data
- wstrb  in  4  byte-lane enables
- wlast  in  1  master's last-beat marker
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  4  echoes the latched awid
- bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- bvalid  out  1  B valid
- bready  in  1  B ready

Behaviour:
- Reset:
  - Every output resets to 0, including arready and awready.
  - Both FSMs return to IDLE; any in-progress burst is abandoned with no response.
  - Memory contents are kept.
- Addressing:
  - Word index = addr[ADDR_BITS+1:2].
  - Out of range when addr[31:ADDR_BITS+2] != 0; the check uses the start address only.
- Address stepping:
  - INCR: next address = addr + (1<<size), 32-bit wrap-around.
  - FIXED: address held for every beat.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid&&arready, latch id, addr, len, size, burst and range flag; clear beat counter; arready<=0; go to R_DATA.
  - In the cycle after the AR handshake: rvalid=1, rdata = array[first word], rlast=(len==0), rresp per range flag.
  - rid, rdata, rresp and rlast stay stable while rvalid&&!rready.
  - On rvalid&&rready with the beat not last: step the address, load the next word and increment the counter in the same edge. This gives one beat per cycle under continuous rready.
  - On acceptance of the last beat: rvalid<=0, arready<=1, return to R_IDLE.
  - A new AR is accepted no earlier than the cycle after the last R beat is accepted.
  - DECERR reads: rdata=0, same beat count and rlast timing as a normal burst.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1, wready=0. W beats that arrive before AW wait.
  - On the AW handshake: latch fields, awready<=0, wready<=1, go to W_DATA.
  - W_DATA: each wvalid&&wready writes the bytes of wdata enabled by wstrb to array[word]; the address steps and the counter increments.
  - On the beat where counter==len: wready<=0, bvalid<=1, go to W_RESP.
  - bresp priority: DECERR if out of range (writes suppressed) > SLVERR if wlast did not match counter==len on any beat > OKAY.
  - The wlast mismatch does not alter the beat count.
  - W_RESP: hold bid and bresp until bvalid&&bready, then bvalid<=0, awready<=1, return to W_IDLE.
- Simultaneous events:
  - Read and write channels are fully independent.
  - If an R-beat load and a W-beat write hit the same word on the same edge, the R beat loads the old data (read-before-write).
- Narrow transfers (size<2): rdata is the whole aligned word; the master selects lanes. Writes rely solely on wstrb.
- arlen and awlen up to 255 must be supported; the counter is 8 bits.

Test Plan:
1. INCR write with awaddr=0x100, awlen=3, size=2, data 0x11,0x22,0x33,0x44, wstrb=F, bready=1 -> 4 writes, bvalid one cycle after the 4th beat with bresp=00 and bid equal to awid.
2. INCR read of the same burst (araddr=0x100, arlen=3), rready=1 -> rvalid the cycle after the handshake, 4 consecutive beats 0x11..0x44, rlast on the 4th only, rresp=00.
3. Toggle rready 1,0,0,1 mid-burst -> rdata, rid and rlast held stable while stalled, no beat lost or duplicated.
4. Single write to 0x200 with wdata=0xAABBCCDD, wstrb=0101 over a word holding 0 -> readback returns 0x00BB00DD.
5. Out-of-range address 0x00010000 with ADDR_BITS=12 -> read returns rresp=11 and rdata=0 on all beats; write gets bresp=11 and memory is unchanged.
6. Apply resetn=0 after 2 of 4 R beats -> all outputs 0; after release arready=1 and a new read completes normally. Also: a write with wlast asserted on beat 2 of 4 -> bresp=10 after 4 beats.

Source files
------------

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave responder backed by a word-addressed on-chip SRAM
module axi_sram_slave #(
    parameter int ADDR_BITS = 12,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Contents survive reset; only time-zero fill is applied.
    logic [31:0] mem [DEPTH] = '{default: ((INIT_ZERO != 0) ? 32'h0 : 32'hx)};

    function automatic logic [ADDR_BITS-1:0] word_idx(input logic [31:0] a);
        return a[ADDR_BITS+1:2];
    endfunction

    function automatic logic out_of_range(input logic [31:0] a);
        return a[31:ADDR_BITS+2] != '0;
    endfunction

    function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (32'd1 << size);
    endfunction

    logic unused_wid;
    assign unused_wid = ^wid;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t    r_state, r_next;
    logic [31:0] r_addr;
    logic [31:0] r_addr_nxt;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_oor;
    logic [7:0]  r_cnt;
    logic        ar_fire, r_fire;

    assign ar_fire    = arvalid && arready;
    assign r_fire     = rvalid && rready;
    assign r_addr_nxt = step_addr(r_addr, r_size, r_burst);

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_next = R_DATA;
            R_DATA:  if (r_fire && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Each accepted beat pre-loads the following word so R runs one beat per cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= 4'd0;
            rdata   <= 32'd0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
            r_addr  <= 32'd0;
            r_len   <= 8'd0;
            r_size  <= 3'd0;
            r_burst <= 2'b00;
            r_oor   <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= r_next;
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (ar_fire) begin
                        arready <= 1'b0;
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_oor   <= out_of_range(araddr);
                        r_cnt   <= 8'd0;
                        rid     <= arid;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == 8'd0);
                        rresp   <= out_of_range(araddr) ? 2'b11 : 2'b00;
                        rdata   <= out_of_range(araddr) ? 32'd0 : mem[word_idx(araddr)];
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                        end else begin
                            r_addr <= r_addr_nxt;
                            r_cnt  <= r_cnt + 8'd1;
                            rlast  <= ((r_cnt + 8'd1) == r_len);
                            rdata  <= r_oor ? 32'd0 : mem[word_idx(r_addr_nxt)];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    w_state_t    w_state, w_next;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_oor;
    logic [7:0]  w_cnt;
    logic        w_err;
    logic        aw_fire, w_fire, w_is_last, w_mismatch, mem_we;

    assign aw_fire    = awvalid && awready;
    assign w_fire     = wvalid && wready;
    assign w_is_last  = (w_cnt == w_len);
    assign w_mismatch = (wlast != w_is_last);
    assign mem_we     = resetn && (w_state == W_DATA) && w_fire && !w_oor;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_next = W_DATA;
            W_DATA:  if (w_fire && w_is_last) w_next = W_RESP;
            W_RESP:  if (bvalid && bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Beat count comes from awlen alone; a misplaced wlast only taints the response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= 4'd0;
            bresp   <= 2'b00;
            w_addr  <= 32'd0;
            w_len   <= 8'd0;
            w_size  <= 3'd0;
            w_burst <= 2'b00;
            w_oor   <= 1'b0;
            w_cnt   <= 8'd0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_next;
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (aw_fire) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_oor   <= out_of_range(awaddr);
                        w_cnt   <= 8'd0;
                        w_err   <= 1'b0;
                        bid     <= awid;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= step_addr(w_addr, w_size, w_burst);
                        w_cnt  <= w_cnt + 8'd1;
                        if (w_is_last) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bresp  <= w_oor ? 2'b11 : ((w_err || w_mismatch) ? 2'b10 : 2'b00);
                        end else begin
                            w_err <= w_err | w_mismatch;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Separate unreset process so the array maps onto a plain RAM write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - self-checking bench for axi_sram_slave against a queue/array model
module tb_axi_sram_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, awvalid, wvalid, wlast, rready, bready;
    logic [3:0]  wstrb;
    logic        arready, rlast, rvalid, awready, wready, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    always #5 clk = ~clk;

    axi_sram_slave #(.ADDR_BITS(12), .INIT_ZERO(1)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [31:0] rcap[$];
    logic [31:0] mdl [4096];
    logic [31:0] wd [8];
    logic [3:0]  ws [8];
    logic [1:0]  last_bresp;
    int          total = 0;
    int          bad = 0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return a[31:14] != 18'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cap(input int i, input logic [31:0] exp);
        if (i < rcap.size()) chk("r_literal", rcap[i], exp);
        else chk("r_literal_missing", 32'(rcap.size()), 32'(i + 1));
    endtask

    // Every cycle R is valid its beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (resetn && rvalid) begin
            if (rq.size() == 0) begin
                chk("r_unexpected_beat", 32'(rvalid), 32'd0);
            end else begin
                chk("rdata", rdata, rq[0].data);
                chk("rid", 32'(rid), 32'(rq[0].id));
                chk("rresp", 32'(rresp), 32'(rq[0].resp));
                chk("rlast", 32'(rlast), 32'(rq[0].last));
                if (rready) begin
                    rcap.push_back(rdata);
                    void'(rq.pop_front());
                end
            end
        end
    end

    task automatic start_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic rr0,
                              output bit ok);
        logic [31:0] a;
        rbeat_t      e;
        a = addr;
        rcap.delete();
        for (int i = 0; i <= int'(len); i++) begin
            e.data = oor(addr) ? 32'd0 : mdl[widx(a)];
            e.resp = oor(addr) ? 2'b11 : 2'b00;
            e.last = (i == int'(len));
            e.id   = id;
            rq.push_back(e);
            if (burst != 2'b00) a = a + (32'd1 << size);
        end
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1; rready = rr0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("ar_timeout", 32'd0, 32'd1);
            arvalid = 1'b0;
            rq.delete();
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("r_first_latency", 32'(rvalid), 32'd1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] pat);
        bit ok;
        int k;
        start_read(id, addr, len, size, burst, pat[0], ok);
        if (!ok) return;
        k = 1;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            if (rq.size() == 0) break;
            rready = pat[k % 4];
            k++;
        end
        if (rq.size() != 0) begin
            chk("r_drain_timeout", 32'(rq.size()), 32'd0);
            rq.delete();
        end
        rready = 1'b1;
        @(negedge clk);
        chk("r_end_rvalid", 32'(rvalid), 32'd0);
        chk("r_end_arready", 32'(arready), 32'd1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_at);
        logic [31:0] a;
        logic [1:0]  exp_resp;
        bit          ok;
        exp_resp = oor(addr) ? 2'b11 : ((last_at != int'(len)) ? 2'b10 : 2'b00);
        a = addr;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        wvalid = 1'b1; wdata = wd[0]; wstrb = ws[0]; wlast = (last_at == 0);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("aw_timeout", 32'd0, 32'd1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (wready) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                chk("w_timeout", 32'd0, 32'd1);
                wvalid = 1'b0;
                return;
            end
            @(posedge clk);
            if (!oor(addr)) begin
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mdl[widx(a)][8*b +: 8] = wd[i][8*b +: 8];
            end
            if (burst != 2'b00) a = a + (32'd1 << size);
            #1;
            if (i < int'(len)) begin
                wdata = wd[i+1]; wstrb = ws[i+1]; wlast = (last_at == i + 1);
            end else begin
                wvalid = 1'b0; wlast = 1'b0;
            end
        end
        @(negedge clk);
        chk("b_latency", 32'(bvalid), 32'd1);
        chk("bresp", 32'(bresp), 32'(exp_resp));
        chk("bid", 32'(bid), 32'(id));
        chk("w_wready_off", 32'(wready), 32'd0);
        last_bresp = bresp;
        @(negedge clk);
        chk("b_done", 32'(bvalid), 32'd0);
        chk("aw_ready_again", 32'(awready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench stuck");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 4096; i++) mdl[i] = 32'd0;
        resetn = 1'b0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; rready = 1'b1; bready = 1'b1;
        last_bresp = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_arready", 32'(arready), 32'd1);
        chk("post_rst_awready", 32'(awready), 32'd1);

        // INCR write then read-back, continuous and stalled
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 8; i++) ws[i] = 4'hF;
        do_write(4'd3, 32'h100, 8'd3, 3'd2, 2'b01, 3);
        do_read(4'd3, 32'h100, 8'd3, 3'd2, 2'b01, 4'b1111);
        chk_cap(0, 32'h11); chk_cap(1, 32'h22); chk_cap(2, 32'h33); chk_cap(3, 32'h44);
        do_read(4'd9, 32'h100, 8'd3, 3'd2, 2'b01, 4'b1001);
        chk_cap(0, 32'h11); chk_cap(3, 32'h44);

        // byte strobes over a zero word
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(4'd1, 32'h200, 8'd0, 3'd2, 2'b01, 0);
        do_read(4'd1, 32'h200, 8'd0, 3'd2, 2'b01, 4'b1111);
        chk_cap(0, 32'h00BB00DD);

        // out of range: DECERR, no write, alias word 0 unchanged
        do_read(4'd2, 32'h0001_0000, 8'd1, 3'd2, 2'b01, 4'b1111);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'd2, 32'h0001_0000, 8'd0, 3'd2, 2'b01, 0);
        chk("oor_bresp_literal", 32'(last_bresp), 32'd3);
        do_read(4'd2, 32'h0, 8'd0, 3'd2, 2'b01, 4'b1111);
        chk_cap(0, 32'h0);

        // reset after two of four beats
        start_read(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1, ok);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (rq.size() <= 2) break;
        end
        resetn = 1'b0; rready = 1'b0;
        rq.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_outs", {arready, rvalid, rlast, rresp, rid, awready, wready, bvalid, bresp, bid},
            32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_arready", 32'(arready), 32'd1);
        do_read(4'd6, 32'h100, 8'd3, 3'd2, 2'b01, 4'b1111);
        chk_cap(1, 32'h22); chk_cap(3, 32'h44);

        // early wlast gives SLVERR but still writes all four beats
        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        for (int i = 0; i < 8; i++) ws[i] = 4'hF;
        do_write(4'd7, 32'h300, 8'd3, 3'd2, 2'b01, 1);
        chk("slverr_literal", 32'(last_bresp), 32'd2);
        do_read(4'd7, 32'h300, 8'd3, 3'd2, 2'b01, 4'b1111);
        chk_cap(3, 32'hA3);

        // FIXED bursts hold the address
        wd[0] = 32'h1; wd[1] = 32'h2;
        do_write(4'd4, 32'h400, 8'd1, 3'd2, 2'b00, 1);
        do_read(4'd4, 32'h400, 8'd2, 3'd2, 2'b00, 4'b1111);
        chk_cap(0, 32'h2); chk_cap(2, 32'h2);

        // byte-size INCR crossing into the next word
        do_read(4'd8, 32'h101, 8'd3, 3'd0, 2'b01, 4'b1111);
        chk_cap(2, 32'h11); chk_cap(3, 32'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
